// File: rtl/axis_rr_fifo_arbiter.sv
// +--------------------------------------------------------------------------+
// | axis_rr_fifo_arbiter: packet-level round-robin sharing of one FIFO       |
// | write port among N_SRC AXI-stream sources, plus FIFO-to-master read side. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module axis_rr_fifo_arbiter #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 8,
  parameter int GW    = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC-1:0]       s_valid,
  output logic [N_SRC-1:0]       s_ready,
  input  logic [N_SRC*WIDTH-1:0] s_data,
  input  logic [N_SRC-1:0]       s_last,
  output logic                   fifo_push,
  output logic [WIDTH:0]         fifo_wdata,
  input  logic                   fifo_full,
  output logic                   fifo_pop,
  input  logic [WIDTH:0]         fifo_rdata,
  input  logic                   fifo_empty,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last,
  output logic [GW-1:0]          grant_id,
  output logic                   busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] rr_ptr_nxt;
  logic [GW-1:0] grant_nxt;
  logic [GW-1:0] winner;
  logic          any_req;
  logic          sel_valid;
  logic          sel_last;
  logic [WIDTH-1:0] sel_data;

  // Scan in reverse so the first requester after rr_ptr is the final assignment.
  always_comb begin
    int idx;
    winner  = '0;
    any_req = |s_valid;
    idx     = 0;
    for (int i = N_SRC; i >= 1; i--) begin
      idx = (int'(rr_ptr) + i) % N_SRC;
      if (s_valid[idx]) winner = idx[GW-1:0];
    end
  end

  always_comb begin
    sel_valid = s_valid[grant_id];
    sel_last  = s_last[grant_id];
    sel_data  = s_data[int'(grant_id)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= GW'(N_SRC - 1);
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt = winner;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (sel_valid && !fifo_full && sel_last) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready    = '0;
    fifo_push  = 1'b0;
    busy       = (state == LOCKED);
    fifo_wdata = {sel_last, sel_data};
    if (state == LOCKED) begin
      s_ready[grant_id] = ~fifo_full;
      fifo_push         = sel_valid & ~fifo_full;
    end
  end

  // Read side is purely combinational and runs regardless of arbitration state.
  always_comb begin
    m_valid  = ~fifo_empty;
    fifo_pop = ~fifo_empty & m_ready;
    m_data   = fifo_rdata[WIDTH-1:0];
    m_last   = fifo_rdata[WIDTH];
  end

endmodule

`default_nettype wire
